// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with private instruction/data memories.
// Fetch, decode, execute, memory and write-back all complete within one clock.

module rv32i_imem #(
  parameter int unsigned BYTES = 4096
) (
  input  logic [31:0] pc,
  output logic [31:0] instruction
);
  localparam int unsigned AW = $clog2(BYTES);

  logic [7:0]    mem [0:BYTES-1];
  logic [AW-1:0] a;
  logic          unused_pc_hi;

  assign a            = pc[AW-1:0];
  assign instruction  = {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
  assign unused_pc_hi = ^pc[31:AW];
endmodule

module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        write_e,
  input  logic [31:0] write_d,
  output logic [31:0] read_d1,
  output logic [31:0] read_d2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_e && (rd != 5'd0)) begin
      regs[rd] <= write_d;
    end
  end

  assign read_d1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign read_d2 = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

module rv32i_ctrl (
  input  logic [31:0] instruction,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  output logic        sel_next_pc_alu_out,
  output logic        sel_wb,
  output logic        sel_alu_pc,
  output logic        sel_alu_imm,
  output logic [3:0]  alu_op,
  output logic        sel_dmem_wb,
  output logic        mem_wr_en,
  output logic [3:0]  mem_byt_en,
  output logic        sign_ext,
  output logic        reg_wr_en,
  output logic        is_jalr,
  output logic        halt,
  output logic [31:0] imm
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  width_en;
  logic        taken;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u    = {instruction[31:12], 12'b0};
  assign imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    case (funct3[1:0])
      2'b00:   width_en = 4'b0001;
      2'b01:   width_en = 4'b0011;
      default: width_en = 4'b1111;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = br_eq;
      3'b001:  taken = !br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = !br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = !br_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Unrecognised opcodes keep every default and therefore act as a NOP.
  always_comb begin
    sel_next_pc_alu_out = 1'b0;
    sel_wb              = 1'b0;
    sel_alu_pc          = 1'b0;
    sel_alu_imm         = 1'b0;
    alu_op              = 4'b0000;
    sel_dmem_wb         = 1'b0;
    mem_wr_en           = 1'b0;
    mem_byt_en          = 4'b0000;
    sign_ext            = 1'b0;
    reg_wr_en           = 1'b0;
    is_jalr             = 1'b0;
    halt                = 1'b0;
    imm                 = '0;
    case (opcode)
      OP_LUI: begin
        reg_wr_en   = 1'b1;
        sel_alu_imm = 1'b1;
        alu_op      = 4'b1111;
        imm         = imm_u;
      end
      OP_AUIPC: begin
        reg_wr_en   = 1'b1;
        sel_alu_pc  = 1'b1;
        sel_alu_imm = 1'b1;
        imm         = imm_u;
      end
      OP_JAL: begin
        reg_wr_en           = 1'b1;
        sel_wb              = 1'b1;
        sel_alu_pc          = 1'b1;
        sel_alu_imm         = 1'b1;
        sel_next_pc_alu_out = 1'b1;
        imm                 = imm_j;
      end
      OP_JALR: begin
        reg_wr_en           = 1'b1;
        sel_wb              = 1'b1;
        sel_alu_imm         = 1'b1;
        sel_next_pc_alu_out = 1'b1;
        is_jalr             = 1'b1;
        imm                 = imm_i;
      end
      OP_BRANCH: begin
        sel_alu_pc          = 1'b1;
        sel_alu_imm         = 1'b1;
        sel_next_pc_alu_out = taken;
        imm                 = imm_b;
      end
      OP_LOAD: begin
        reg_wr_en   = 1'b1;
        sel_alu_imm = 1'b1;
        sel_dmem_wb = 1'b1;
        mem_byt_en  = width_en;
        sign_ext    = !funct3[2];
        imm         = imm_i;
      end
      OP_STORE: begin
        mem_wr_en   = 1'b1;
        sel_alu_imm = 1'b1;
        mem_byt_en  = width_en;
        imm         = imm_s;
      end
      OP_IMM: begin
        reg_wr_en   = 1'b1;
        sel_alu_imm = 1'b1;
        // Bit 30 selects the alternate op only for SRAI; elsewhere it is immediate data.
        alu_op      = {(funct3 == 3'b101) && funct7_5, funct3};
        imm         = imm_i;
      end
      OP_REG: begin
        reg_wr_en = 1'b1;
        alu_op    = {funct7_5, funct3};
      end
      OP_SYSTEM: begin
        halt = (instruction == EBREAK);
      end
      default: ;
    endcase
  end
endmodule

module rv32i_core #(
  parameter int unsigned IMEM_BYTES = 4096,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned DAW = $clog2(DMEM_BYTES);

  logic [31:0] pc_out, instruction, alu_out, reg_data1, reg_data2, imm;
  logic [31:0] alu_in1, alu_in2, pc_plus4, next_pc, load_data, wb_data, d_rdata;
  logic        sel_next_pc_alu_out, sel_wb, sel_alu_pc, sel_alu_imm, sel_dmem_wb;
  logic        mem_wr_en, sign_ext, reg_wr_en, is_jalr, halt;
  logic [3:0]  alu_op, mem_byt_en;
  logic        br_eq, br_lt, br_ltu;
  logic [DAW-1:0] d_addr;
  logic [7:0]  d_mem [0:DMEM_BYTES-1];

  rv32i_imem #(.BYTES(IMEM_BYTES)) i_mem (
    .pc          (pc_out),
    .instruction (instruction)
  );

  rv32i_ctrl ctrl (
    .instruction         (instruction),
    .br_eq               (br_eq),
    .br_lt               (br_lt),
    .br_ltu              (br_ltu),
    .sel_next_pc_alu_out (sel_next_pc_alu_out),
    .sel_wb              (sel_wb),
    .sel_alu_pc          (sel_alu_pc),
    .sel_alu_imm         (sel_alu_imm),
    .alu_op              (alu_op),
    .sel_dmem_wb         (sel_dmem_wb),
    .mem_wr_en           (mem_wr_en),
    .mem_byt_en          (mem_byt_en),
    .sign_ext            (sign_ext),
    .reg_wr_en           (reg_wr_en),
    .is_jalr             (is_jalr),
    .halt                (halt),
    .imm                 (imm)
  );

  rv32i_regfile rf (
    .clk     (clk),
    .rst     (rst),
    .rs1     (instruction[19:15]),
    .rs2     (instruction[24:20]),
    .rd      (instruction[11:7]),
    .write_e (reg_wr_en),
    .write_d (wb_data),
    .read_d1 (reg_data1),
    .read_d2 (reg_data2)
  );

  assign br_eq  = (reg_data1 == reg_data2);
  assign br_lt  = ($signed(reg_data1) < $signed(reg_data2));
  assign br_ltu = (reg_data1 < reg_data2);

  assign alu_in1 = sel_alu_pc  ? pc_out : reg_data1;
  assign alu_in2 = sel_alu_imm ? imm    : reg_data2;

  always_comb begin
    case (alu_op)
      4'b1000: alu_out = alu_in1 - alu_in2;
      4'b0001: alu_out = alu_in1 << alu_in2[4:0];
      4'b0010: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
      4'b0011: alu_out = {31'b0, alu_in1 < alu_in2};
      4'b0100: alu_out = alu_in1 ^ alu_in2;
      4'b0101: alu_out = alu_in1 >> alu_in2[4:0];
      4'b1101: alu_out = 32'($signed(alu_in1) >>> alu_in2[4:0]);
      4'b0110: alu_out = alu_in1 | alu_in2;
      4'b0111: alu_out = alu_in1 & alu_in2;
      4'b1111: alu_out = alu_in2;
      default: alu_out = alu_in1 + alu_in2;
    endcase
  end

  // Byte-wise data memory: addresses wrap, misaligned accesses just touch consecutive bytes.
  assign d_addr  = alu_out[DAW-1:0];
  assign d_rdata = {d_mem[d_addr + DAW'(3)], d_mem[d_addr + DAW'(2)],
                    d_mem[d_addr + DAW'(1)], d_mem[d_addr]};

  always_ff @(posedge clk) begin
    if (!rst && mem_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_byt_en[k]) d_mem[d_addr + DAW'(k)] <= reg_data2[8*k +: 8];
      end
    end
  end

  always_comb begin
    case (mem_byt_en)
      4'b0001: load_data = sign_ext ? {{24{d_rdata[7]}}, d_rdata[7:0]}
                                    : {24'b0, d_rdata[7:0]};
      4'b0011: load_data = sign_ext ? {{16{d_rdata[15]}}, d_rdata[15:0]}
                                    : {16'b0, d_rdata[15:0]};
      default: load_data = d_rdata;
    endcase
  end

  assign pc_plus4 = pc_out + 32'd4;
  assign wb_data  = sel_wb ? pc_plus4 : (sel_dmem_wb ? load_data : alu_out);
  assign next_pc  = sel_next_pc_alu_out ? {alu_out[31:1], alu_out[0] & !is_jalr} : pc_plus4;

  // EBREAK holds the PC on itself, so the core stays parked until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pc_out <= '0;
    else if (!halt) pc_out <= next_pc;
  end
endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: random and directed programs run against an instruction-level model.
module tb_rv32i_core;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_core #(.IMEM_BYTES(4096), .DMEM_BYTES(4096)) dut (.clk(clk), .rst(rst));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        st;
    logic [3:0]  be;
  } rec_t;

  rec_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] prog [0:1023];
  int          prog_len;
  logic [31:0] m_reg [0:31];
  logic [7:0]  m_mem [0:4095];
  logic [31:0] halt_pc;
  logic [2:0]  ld_f3 [0:4] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  br_f3 [0:5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [4:0] rnd_reg();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic emit(input logic [31:0] w);
    prog[prog_len] = w;
    prog_len++;
  endtask

  task automatic emit_filler();
    emit(enc_i(12'($urandom), rnd_reg(), 3'd0, rnd_reg(), 7'h13));
  endtask

  // ISA semantics of the register/immediate arithmetic group.
  function automatic logic [31:0] calc(input logic [2:0] f3, input logic alt,
      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Instruction-set model: walks the program and queues one record per retired instruction.
  task automatic run_model();
    logic [31:0] pc, ins, a, b, ii, si, bi, ui, ji, addr, v, npc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        taken;
    int          nb;
    rec_t        r;
    pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int steps = 0; steps < 4000; steps++) begin
      ins = prog[pc[11:2]];
      f3  = ins[14:12];
      rd  = ins[11:7];
      a   = m_reg[ins[19:15]];
      b   = m_reg[ins[24:20]];
      ii  = {{20{ins[31]}}, ins[31:20]};
      si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ui  = {ins[31:12], 12'b0};
      ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      r.pc = pc; r.instr = ins; r.wr = 1'b0; r.rd = rd; r.wd = 32'd0; r.st = 1'b0; r.be = 4'd0;
      npc = pc + 32'd4;
      case (ins[6:0])
        7'h37: begin r.wr = 1'b1; r.wd = ui; end
        7'h17: begin r.wr = 1'b1; r.wd = pc + ui; end
        7'h6f: begin r.wr = 1'b1; r.wd = pc + 32'd4; npc = pc + ji; end
        7'h67: begin r.wr = 1'b1; r.wd = pc + 32'd4; npc = (a + ii) & ~32'd1; end
        7'h63: begin
          case (f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) < $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a < b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
          endcase
          if (taken) npc = pc + bi;
        end
        7'h03: begin
          addr = a + ii;
          for (int k = 0; k < 4; k++) v[8*k +: 8] = m_mem[12'(addr + 32'(k))];
          case (f3)
            3'd0:    r.wd = {{24{v[7]}}, v[7:0]};
            3'd1:    r.wd = {{16{v[15]}}, v[15:0]};
            3'd4:    r.wd = {24'd0, v[7:0]};
            3'd5:    r.wd = {16'd0, v[15:0]};
            default: r.wd = v;
          endcase
          r.wr = 1'b1;
        end
        7'h23: begin
          addr = a + si;
          nb   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
          for (int k = 0; k < nb; k++) m_mem[12'(addr + 32'(k))] = b[8*k +: 8];
          r.st = 1'b1;
          r.be = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
        end
        7'h13: begin r.wr = 1'b1; r.wd = calc(f3, (f3 == 3'd5) && ins[30], a, ii); end
        7'h33: begin r.wr = 1'b1; r.wd = calc(f3, ins[30], a, b); end
        default: ;
      endcase
      exp_q.push_back(r);
      if (ins == EBREAK) begin
        halt_pc = pc;
        break;
      end
      if (r.wr && rd != 5'd0) m_reg[rd] = r.wd;
      pc = npc;
    end
  endtask

  task automatic gen_random();
    int kind, off, sub;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  t;
    logic [11:0] imm;
    prog_len = 0;
    for (int r = 1; r < 32; r++) begin
      emit(enc_u(20'($urandom), 5'(r), 7'h37));
      emit(enc_i(12'($urandom), 5'(r), 3'd0, 5'(r), 7'h13));
    end
    // Seed every byte that later loads can reach, including the wrap-around tail.
    for (int o = -4; o <= 68; o += 4) emit(enc_s(12'(o), rnd_reg(), 5'd0, 3'd2));
    repeat (300) begin
      kind = int'($urandom_range(0, 9));
      off  = int'($urandom_range(0, 67)) - 4;
      f3   = 3'($urandom_range(0, 7));
      alt  = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2: emit(enc_r(((f3 == 3'd0 || f3 == 3'd5) && alt) ? 7'h20 : 7'h00,
                            rnd_reg(), rnd_reg(), f3, rnd_reg()));
        3, 4: begin
          if (f3 == 3'd1)      imm = {7'h00, 5'($urandom)};
          else if (f3 == 3'd5) imm = {alt ? 7'h20 : 7'h00, 5'($urandom)};
          else                 imm = 12'($urandom);
          emit(enc_i(imm, rnd_reg(), f3, rnd_reg(), 7'h13));
        end
        5: emit(enc_i(12'(off), 5'd0, ld_f3[$urandom_range(0, 4)], rnd_reg(), 7'h03));
        6: emit(enc_s(12'(off), rnd_reg(), 5'd0, 3'($urandom_range(0, 2))));
        7: begin
          emit(enc_b(13'd8, rnd_reg(), rnd_reg(), br_f3[$urandom_range(0, 5)]));
          emit_filler();
        end
        8: begin
          emit(enc_j(21'd8, rnd_reg()));
          emit_filler();
        end
        default: begin
          sub = int'($urandom_range(0, 3));
          if (sub == 0)      emit(enc_u(20'($urandom), rnd_reg(), 7'h37));
          else if (sub == 1) emit(enc_u(20'($urandom), rnd_reg(), 7'h17));
          else if (sub == 2) begin
            t = rnd_reg();
            if (t == 5'd0) t = 5'd31;
            emit(enc_u(20'd0, t, 7'h17));
            emit(enc_i(12'(12 + $urandom_range(0, 1)), t, 3'd0, rnd_reg(), 7'h67));
            emit_filler();
          end else emit(32'h0000_0073);
        end
      endcase
    end
    emit(EBREAK);
  endtask

  task automatic gen_directed();
    prog_len = 0;
    emit(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
    emit(enc_i(12'(-7), 5'd1, 3'd0, 5'd2, 7'h13));
    emit(enc_u(20'h12345, 5'd3, 7'h37));
    emit(enc_i(12'h678, 5'd3, 3'd0, 5'd3, 7'h13));
    emit(enc_s(12'd0, 5'd3, 5'd0, 3'd2));
    emit(enc_i(12'd0, 5'd0, 3'd0, 5'd4, 7'h03));
    emit(enc_i(12'd3, 5'd0, 3'd4, 5'd5, 7'h03));
    emit(enc_i(12'd0, 5'd0, 3'd1, 5'd6, 7'h03));
    emit(enc_i(12'd5, 5'd0, 3'd0, 5'd2, 7'h13));
    emit(enc_b(13'd8, 5'd2, 5'd1, 3'd0));
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13));
    emit(enc_b(13'd8, 5'd2, 5'd1, 3'd1));
    emit(enc_u(20'h80000, 5'd8, 7'h37));
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13));
    emit(enc_r(7'h20, 5'd9, 5'd8, 3'd0, 5'd10));
    emit(enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd11));
    emit(enc_r(7'h00, 5'd9, 5'd8, 3'd3, 5'd12));
    emit(enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'h13));
    emit(enc_i(12'(-1), 5'd0, 3'd0, 5'd13, 7'h13));
    emit(enc_b(13'd8, 5'd9, 5'd13, 3'd4));
    emit(enc_i(12'd2, 5'd0, 3'd0, 5'd7, 7'h13));
    emit(enc_b(13'd8, 5'd9, 5'd13, 3'd6));
    emit(enc_j(21'd12, 5'd14));
    emit(enc_i(12'd3, 5'd0, 3'd0, 5'd7, 7'h13));
    emit(enc_i(12'd4, 5'd0, 3'd0, 5'd7, 7'h13));
    emit(enc_i(12'd12, 5'd14, 3'd0, 5'd0, 7'h67));
    emit(enc_i(12'h077, 5'd0, 3'd0, 5'd15, 7'h13));
    emit(EBREAK);
  endtask

  // Monitor: every cycle the core is out of reset, compare the instruction about to retire.
  always @(negedge clk) begin
    rec_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("pc_seq@%08h", e.pc), dut.pc_out, e.pc);
      check($sformatf("instr@%08h", e.pc), dut.instruction, e.instr);
      check($sformatf("write_e@%08h", e.pc), 32'(dut.rf.write_e), 32'(e.wr));
      check($sformatf("mem_wr_en@%08h", e.pc), 32'(dut.ctrl.mem_wr_en), 32'(e.st));
      if (e.wr) begin
        check($sformatf("rd@%08h", e.pc), 32'(dut.rf.rd), 32'(e.rd));
        check($sformatf("write_d@%08h", e.pc), dut.rf.write_d, e.wd);
      end
      if (e.st) check($sformatf("byt_en@%08h", e.pc), 32'(dut.ctrl.mem_byt_en), 32'(e.be));
    end
  end

  task automatic run_program();
    int n;
    rst = 1'b1;
    for (int i = 0; i < prog_len; i++)
      for (int k = 0; k < 4; k++) dut.i_mem.mem[4*i + k] = prog[i][8*k +: 8];
    run_model();
    @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("retire_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    check("halt_pc", dut.pc_out, halt_pc);
    check("halt_instr", dut.instruction, EBREAK);
    check("halt_write_e", 32'(dut.rf.write_e), 32'd0);
    check("halt_mem_wr", 32'(dut.ctrl.mem_wr_en), 32'd0);
    for (int i = 1; i < 32; i++) check($sformatf("final_x%0d", i), dut.rf.regs[i], m_reg[i]);
  endtask

  task automatic reset_check();
    int nz;
    #3 rst = 1'b1;
    #1;
    check("rst_pc", dut.pc_out, 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf.regs[i] !== 32'd0) nz++;
    check("rst_regs_nonzero", 32'(nz), 32'd0);
  endtask

  initial begin
    gen_random();
    run_program();
    reset_check();
    gen_directed();
    run_program();
    check("dir_x1", dut.rf.regs[1], 32'h0000_0005);
    check("dir_x2", dut.rf.regs[2], 32'h0000_0005);
    check("dir_x3", dut.rf.regs[3], 32'h1234_5678);
    check("dir_lb_x4", dut.rf.regs[4], 32'h0000_0078);
    check("dir_lbu_x5", dut.rf.regs[5], 32'h0000_0012);
    check("dir_lh_x6", dut.rf.regs[6], 32'h0000_5678);
    check("dir_skipped_x7", dut.rf.regs[7], 32'h0000_0000);
    check("dir_sub_x10", dut.rf.regs[10], 32'h7FFF_FFFF);
    check("dir_sra_x11", dut.rf.regs[11], 32'hC000_0000);
    check("dir_sltu_x12", dut.rf.regs[12], 32'h0000_0000);
    check("dir_jal_x14", dut.rf.regs[14], 32'h0000_005C);
    check("dir_jalr_x15", dut.rf.regs[15], 32'h0000_0077);
    check("dir_halt_pc", dut.pc_out, 32'h0000_006C);
    reset_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
